// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between fetch, data (LM/SM bursts) and loader.
// Fixed priority data > fetch > loader by default; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   input  logic              data_req,
   input  logic              data_we,
   input  logic              data_lock,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_w_bar,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_DATA  = 2'd2;
   localparam logic [1:0] OWN_LDR   = 2'd3;

   state_t              state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [3:0]          hold_q, hold_d;
   logic [1:0]          grant;
   logic                cont;

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] rr_last_q, rr_last_d;
   logic [3:0] req_by;
   logic [1:0] c0, c1, c2;

   function automatic logic [1:0] rr_next(input logic [1:0] c);
      return (c == OWN_LDR) ? OWN_FETCH : c + 2'd1;
   endfunction

   // Search starts just after the last owner; "none" behaves like loader so fetch leads.
   always_comb begin
      req_by = {ldr_req, data_req, fetch_req, 1'b0};
      c0     = (rr_last_q == OWN_NONE) ? OWN_FETCH : rr_next(rr_last_q);
      c1     = rr_next(c0);
      c2     = rr_next(c1);
      grant  = OWN_NONE;
      if (req_by[c0])      grant = c0;
      else if (req_by[c1]) grant = c1;
      else if (req_by[c2]) grant = c2;
   end
`else
   always_comb begin
      grant = OWN_NONE;
      if (data_req)       grant = OWN_DATA;
      else if (fetch_req) grant = OWN_FETCH;
      else if (ldr_req)   grant = OWN_LDR;
   end
`endif

   // A locked data owner chains straight into the next ISSUE until MAX_HOLD beats are used.
   assign cont = (owner_q == OWN_DATA) && data_lock && data_req &&
                 ((int'(hold_q) + 1) < MAX_HOLD);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      hold_d  = hold_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_d = rr_last_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant != OWN_NONE) begin
               owner_d = grant;
               state_d = ISSUE;
               case (grant)
                  OWN_FETCH: begin
                     addr_d = fetch_addr;
                     we_d   = 1'b0;
                  end
                  OWN_DATA: begin
                     addr_d  = data_addr;
                     wdata_d = data_wdata;
                     we_d    = data_we;
                  end
                  default: begin
                     addr_d  = ldr_addr;
                     wdata_d = ldr_wdata;
                     we_d    = ldr_we;
                  end
               endcase
            end
         end
         ISSUE: state_d = RESP;
         RESP: begin
            if (!we_q) rdata_d = mem_rdata;
            if (cont) begin
               hold_d  = hold_q + 4'd1;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               we_d    = data_we;
               state_d = ISSUE;
            end else begin
               hold_d  = 4'd0;
               owner_d = OWN_NONE;
               state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
               rr_last_d = owner_q;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         hold_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         hold_q  <= hold_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) rr_last_q <= OWN_NONE;
      else        rr_last_q <= rr_last_d;
   end
`endif

   // Strobe decodes straight from the state register, so reset releases it at once.
   assign busy      = (state_q != IDLE);
   assign mem_en    = busy;
   assign mem_w_bar = !((state_q == ISSUE) && we_q);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign owner     = owner_q;
   assign fetch_ack = (state_q == RESP) && (owner_q == OWN_FETCH);
   assign data_ack  = (state_q == RESP) && (owner_q == OWN_DATA);
   assign ldr_ack   = (state_q == RESP) && (owner_q == OWN_LDR);

endmodule
